double_to_float: RTL

Narrowing converter: accepts an IEEE-754 binary64 operand and produces the binary32 value, correctly rounded with round-to-nearest-even. It also raises invalid, overflow, underflow and inexact flags. It is the downstream companion of the float-to-double widening stage and shares its FPU clock/reset domain. Multi-cycle FSM with a valid/ready handshake on both sides; one conversion in flight.

---
 rtl/fp_pkg.sv | 35 +++
 rtl/shift_right_sticky.sv | 18 +
 rtl/double_to_float.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared FPU format constants and converter state encoding for the
// float<->double conversion stages.
package fp_pkg;

  localparam int unsigned DBL_EXP_W = 11;
  localparam int unsigned DBL_MAN_W = 52;
  localparam int unsigned FLT_EXP_W = 8;
  localparam int unsigned FLT_MAN_W = 23;

  localparam int DBL_BIAS = 1023;
  localparam int FLT_BIAS = 127;
  localparam logic signed [11:0] REBIAS = 12'sd896;

  localparam logic [DBL_EXP_W-1:0] DBL_EXP_ONES = 11'h7FF;
  localparam logic [FLT_EXP_W-1:0] FLT_EXP_ONES = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_ROUND,
    ST_OUTPUT
  } cvt_state_e;

  typedef enum logic [2:0] {
    CLS_QNAN,
    CLS_SNAN,
    CLS_INF,
    CLS_ZERO,
    CLS_SUB,
    CLS_OVF,
    CLS_NORM,
    CLS_TINY
  } cvt_class_e;

endpackage

// File: rtl/shift_right_sticky.sv
// 53-bit logical right shift by 0..55, returning the shifted value plus the
// first shifted-out bit (guard) and the OR of all later shifted-out bits (sticky).
module shift_right_sticky (
  input  logic [52:0] val_i,
  input  logic [5:0]  sh_i,
  output logic [52:0] val_o,
  output logic        guard_o,
  output logic        sticky_o
);

  logic [107:0] ext;

  assign ext      = {val_i, 55'd0} >> sh_i;
  assign val_o    = ext[107:55];
  assign guard_o  = ext[54];
  assign sticky_o = |ext[53:0];

endmodule

// File: rtl/double_to_float.sv
// binary64 -> binary32 narrowing converter, round-to-nearest-even, IEEE flags.
// Fixed 4-state FSM: result valid 3 cycles after accept, held until out_ready_i.
module double_to_float
  import fp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] double_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] float_o,
  output logic        nan_exception_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        inexact_o
);

  cvt_state_e  state_q, state_d;
  cvt_class_e  cls_q, cls_d;
  logic [63:0] dbl_q, dbl_d;
  logic [7:0]  exp_q, exp_d;
  logic [5:0]  sh_q, sh_d;
  logic [31:0] float_q, float_d;
  logic        nan_q, nan_d, ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic               sign;
  logic [10:0]        e_fld;
  logic [51:0]        f_fld;
  logic signed [11:0] exp_calc;
  logic [52:0]        shr_val;
  logic               shr_guard, shr_sticky;
  logic [30:0]        base, rounded;
  logic               g, st, inc, rnd_ovf;

  assign sign     = dbl_q[63];
  assign e_fld    = dbl_q[62:52];
  assign f_fld    = dbl_q[51:0];
  assign exp_calc = $signed({1'b0, e_fld}) - REBIAS;

  shift_right_sticky u_shr (
    .val_i    ({1'b1, f_fld}),
    .sh_i     (sh_q),
    .val_o    (shr_val),
    .guard_o  (shr_guard),
    .sticky_o (shr_sticky)
  );

  // Tiny operands are shifted by at least 30, so the shifter output fits in the mantissa field.
  always_comb begin
    if (cls_q == CLS_TINY) begin
      base = 31'(shr_val);
      g    = shr_guard;
      st   = shr_sticky;
    end else begin
      base = {exp_q, f_fld[51:29]};
      g    = f_fld[28];
      st   = |f_fld[27:0];
    end
    inc     = g & (st | base[0]);
    rounded = base + {30'd0, inc};
    rnd_ovf = (rounded[30:23] == FLT_EXP_ONES);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (in_valid_i) state_d = ST_CLASSIFY;
      ST_CLASSIFY: state_d = ST_ROUND;
      ST_ROUND:    state_d = ST_OUTPUT;
      ST_OUTPUT:   if (out_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_OUTPUT);
  end

  always_comb begin
    dbl_d   = dbl_q;
    cls_d   = cls_q;
    exp_d   = exp_q;
    sh_d    = sh_q;
    float_d = float_q;
    nan_d   = nan_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inx_d   = inx_q;
    case (state_q)
      ST_IDLE: if (in_valid_i) dbl_d = double_i;
      ST_CLASSIFY: begin
        exp_d = exp_calc[7:0];
        sh_d  = (exp_calc < -12'sd25) ? 6'd55 : (6'd30 - exp_calc[5:0]);
        if (e_fld == DBL_EXP_ONES) begin
          if (f_fld == '0)    cls_d = CLS_INF;
          else if (f_fld[51]) cls_d = CLS_QNAN;
          else                cls_d = CLS_SNAN;
        end else if (e_fld == '0) begin
          cls_d = (f_fld == '0) ? CLS_ZERO : CLS_SUB;
        end else if (exp_calc >= 12'sd255) begin
          cls_d = CLS_OVF;
        end else if (exp_calc >= 12'sd1) begin
          cls_d = CLS_NORM;
        end else begin
          cls_d = CLS_TINY;
        end
      end
      ST_ROUND: begin
        nan_d = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        case (cls_q)
          CLS_QNAN: float_d = {sign, FLT_EXP_ONES, f_fld[51:29]};
          CLS_SNAN: begin
            float_d = {sign, FLT_EXP_ONES, 1'b1, f_fld[50:29]};
            nan_d   = 1'b1;
          end
          CLS_INF:  float_d = {sign, FLT_EXP_ONES, 23'd0};
          CLS_ZERO: float_d = {sign, 31'd0};
          CLS_SUB: begin
            float_d = {sign, 31'd0};
            unf_d   = 1'b1;
            inx_d   = 1'b1;
          end
          CLS_OVF: begin
            float_d = {sign, FLT_EXP_ONES, 23'd0};
            ovf_d   = 1'b1;
            inx_d   = 1'b1;
          end
          CLS_NORM: begin
            if (rnd_ovf) begin
              float_d = {sign, FLT_EXP_ONES, 23'd0};
              ovf_d   = 1'b1;
              inx_d   = 1'b1;
            end else begin
              float_d = {sign, rounded};
              inx_d   = g | st;
            end
          end
          default: begin
            float_d = {sign, rounded};
            inx_d   = g | st;
            unf_d   = g | st;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbl_q   <= '0;
      cls_q   <= CLS_ZERO;
      exp_q   <= '0;
      sh_q    <= '0;
      float_q <= '0;
      nan_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      dbl_q   <= dbl_d;
      cls_q   <= cls_d;
      exp_q   <= exp_d;
      sh_q    <= sh_d;
      float_q <= float_d;
      nan_q   <= nan_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
    end
  end

  assign float_o         = float_q;
  assign nan_exception_o = nan_q;
  assign overflow_o      = ovf_q;
  assign underflow_o     = unf_q;
  assign inexact_o       = inx_q;

endmodule
